// File: rtl/spi_sram_responder.sv
// SPI SRAM-style responder (23LC-like READ/WRITE/RDMR/WRMR subset).
// SPI pins are oversampled on i_clk and bridged to a simple byte memory port.
module spi_sram_responder #(
    parameter int          ADDR_W   = 16,
    parameter logic [7:0]  MODE_REG = 8'h40
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_spi_clk,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    output logic [ADDR_W-1:0] o_mem_adr,
    output logic [7:0]        o_mem_dat,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [7:0]        i_mem_rdt,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WR,
        S_RD,
        S_RDMR,
        S_IGNORE
    } state_t;

    logic [2:0]        sclk_q;
    logic [2:0]        cs_q;
    logic [1:0]        mosi_q;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [7:0]        rx_q;
    logic [15:0]       adr_sh_q;
    logic [ADDR_W-1:0] addr_q;
    logic              is_wr_q;
    logic [7:0]        tx_q;
    logic [7:0]        pf_q;
    logic [2:0]        rcnt_q;
    logic [2:0]        fcnt_q;
    logic              use_pf_q;
    logic              first_q;
    logic              cap_q;
    logic              miso_q;
    logic              oe_q;
    logic [ADDR_W-1:0] mem_adr_q;
    logic [7:0]        mem_dat_q;
    logic              we_q;
    logic              re_q;

    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_fall;
    logic              cs_rise;
    logic [7:0]        rx_d;
    logic [15:0]       adr_sh_d;
    logic [ADDR_W-1:0] addr_inc_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], i_spi_clk};
            cs_q   <= {cs_q[1:0], i_spi_cs_n};
            mosi_q <= {mosi_q[0], i_spi_mosi};
        end
    end

    // SCLK edges only count while the synchronised chip select is low
    assign sclk_rise  = sclk_q[1] & ~sclk_q[2] & ~cs_q[1];
    assign sclk_fall  = ~sclk_q[1] & sclk_q[2] & ~cs_q[1];
    assign cs_fall    = ~cs_q[1] & cs_q[2];
    assign cs_rise    = cs_q[1] & ~cs_q[2];
    assign rx_d       = {rx_q[6:0], mosi_q[1]};
    assign adr_sh_d   = {adr_sh_q[14:0], mosi_q[1]};
    assign addr_inc_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rx_q      <= '0;
            adr_sh_q  <= '0;
            addr_q    <= '0;
            is_wr_q   <= 1'b0;
            tx_q      <= '0;
            pf_q      <= '0;
            rcnt_q    <= '0;
            fcnt_q    <= '0;
            use_pf_q  <= 1'b0;
            first_q   <= 1'b0;
            cap_q     <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            mem_adr_q <= '0;
            mem_dat_q <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            re_q  <= 1'b0;
            cap_q <= re_q;

            // Read data returns two cycles after the strobe
            if (cap_q) begin
                if (first_q) begin
                    tx_q    <= i_mem_rdt;
                    first_q <= 1'b0;
                end else begin
                    pf_q <= i_mem_rdt;
                end
            end

            if (state_q != S_IDLE && cs_rise) begin
                state_q <= S_IDLE;
                oe_q    <= 1'b0;
                miso_q  <= 1'b0;
                cap_q   <= 1'b0;
                first_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state_q <= S_CMD;
                            cnt_q   <= '0;
                        end
                    end
                    S_CMD: begin
                        if (sclk_rise) begin
                            rx_q  <= rx_d;
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q == 4'd7) begin
                                cnt_q <= '0;
                                case (rx_d)
                                    8'h03: begin
                                        state_q <= S_ADDR;
                                        is_wr_q <= 1'b0;
                                    end
                                    8'h02: begin
                                        state_q <= S_ADDR;
                                        is_wr_q <= 1'b1;
                                    end
                                    8'h05: begin
                                        state_q <= S_RDMR;
                                        tx_q    <= MODE_REG;
                                        oe_q    <= 1'b1;
                                    end
                                    8'h01:   state_q <= S_IGNORE;
                                    default: state_q <= S_IGNORE;
                                endcase
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sclk_rise) begin
                            adr_sh_q <= adr_sh_d;
                            cnt_q    <= cnt_q + 4'd1;
                            if (cnt_q == 4'd15) begin
                                cnt_q  <= '0;
                                addr_q <= adr_sh_d[ADDR_W-1:0];
                                if (is_wr_q) begin
                                    state_q <= S_WR;
                                end else begin
                                    state_q   <= S_RD;
                                    re_q      <= 1'b1;
                                    mem_adr_q <= adr_sh_d[ADDR_W-1:0];
                                    first_q   <= 1'b1;
                                    oe_q      <= 1'b1;
                                    rcnt_q    <= '0;
                                    fcnt_q    <= '0;
                                    use_pf_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    S_WR: begin
                        if (sclk_rise) begin
                            rx_q  <= rx_d;
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q == 4'd7) begin
                                cnt_q     <= '0;
                                we_q      <= 1'b1;
                                mem_adr_q <= addr_q;
                                mem_dat_q <= rx_d;
                                addr_q    <= addr_inc_d;
                            end
                        end
                    end
                    S_RD: begin
                        if (sclk_rise) begin
                            rcnt_q <= rcnt_q + 3'd1;
                            // Prefetch the next byte while bit 7 goes out
                            if (rcnt_q == 3'd0) begin
                                addr_q    <= addr_inc_d;
                                mem_adr_q <= addr_inc_d;
                                re_q      <= 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            fcnt_q <= fcnt_q + 3'd1;
                            if (fcnt_q == 3'd0 && use_pf_q) begin
                                miso_q <= pf_q[7];
                                tx_q   <= {pf_q[6:0], 1'b0};
                            end else begin
                                miso_q <= tx_q[7];
                                tx_q   <= {tx_q[6:0], 1'b0};
                            end
                            if (fcnt_q == 3'd7) begin
                                use_pf_q <= 1'b1;
                            end
                        end
                    end
                    S_RDMR: begin
                        if (sclk_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], tx_q[7]};
                        end
                    end
                    S_IGNORE: begin
                        oe_q <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign o_spi_miso    = miso_q & oe_q;
    assign o_spi_miso_oe = oe_q;
    assign o_mem_adr     = mem_adr_q;
    assign o_mem_dat     = mem_dat_q;
    assign o_mem_we      = we_q;
    assign o_mem_re      = re_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule
